// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: opsel codes, flag indices, FSM states and width shared by the multi-cycle unit.
package muldiv_unit_pkg;
    localparam int W = 16;
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_MUL = 5'd8;
    localparam logic [4:0] ALU_DIV = 5'd9;
    localparam logic [4:0] ALU_MOD = 5'd10;
    localparam logic [4:0] ALU_POW = 5'd11;
    localparam int ZF = 3;
    localparam int NF = 2;
    localparam int CF = 1;
    localparam int OF = 0;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    function automatic logic is_multi(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_DIV, ALU_MOD, ALU_POW};
    endfunction
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one shift-add (multiply) or one restoring shift-subtract (divide) step on 2W-bit state.
module muldiv_core #(
    parameter int W = 16
) (
    input  logic                 div_i,
    input  logic [2*W-1:0]       x_i,
    input  logic [2*W-1:0]       y_i,
    input  logic                 bit_i,
    input  logic [$clog2(W)-1:0] sh_i,
    output logic [2*W-1:0]       x_o
);
    logic [2*W:0] s;
    logic [W:0]   hi;
    logic [W:0]   diff;
    // Divide state is {remainder, dividend/quotient}; the shifted-out bit keeps the trial remainder W+1 wide.
    always_comb begin
        s    = {x_i, 1'b0};
        hi   = s[2*W:W];
        diff = hi - {1'b0, y_i[W-1:0]};
        x_o  = div_i ? {(diff[W] ? hi[W-1:0] : diff[W-1:0]), s[W-1:1], !diff[W]}
                     : x_i + (bit_i ? y_i << sh_i : '0);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MUL/DIV/MOD/POW beside the ALU; ready stalls the control unit while busy.
module muldiv_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   opsel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic [W-1:0] res,
    output logic [W-1:0] res_ext,
    output logic [3:0]   flags
);
    import muldiv_unit_pkg::*;
    localparam logic [4:0] LAST = 5'(W - 1);
    state_e         state_q, state_d;
    logic [4:0]     op_q, op_d, cnt_q, cnt_d, exp_q, exp_d, cur_op;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, ext_q, ext_d;
    logic [2*W-1:0] wk_q, wk_d, pacc_q, pacc_d, core_x, core_y, fin;
    logic [3:0]     flags_q, flags_d;
    logic           div_op, pow_op, load, last_it, last_mul, dz, core_bit;

    assign cur_op   = state_q == IDLE ? opsel : op_q;
    assign div_op   = cur_op inside {ALU_DIV, ALU_MOD};
    assign pow_op   = cur_op == ALU_POW;
    assign core_y   = pow_op ? pacc_q : {{W{1'b0}}, div_op ? b_q : a_q};
    assign core_bit = pow_op ? a_q[cnt_q[3:0]] : b_q[cnt_q[3:0]];
    assign last_it  = cnt_q == LAST;
    assign last_mul = !pow_op || exp_q == b_q[4:0] - 5'd1;
    assign dz       = div_op && state_q == IDLE;
    assign ready    = !rst && (state_q == DONE || (state_q == IDLE && !is_multi(opsel)));
    assign res      = res_q;
    assign res_ext  = ext_q;
    assign flags    = flags_q;

    muldiv_core #(.W(W)) u_core (
        .div_i(div_op),
        .x_i  (wk_q),
        .y_i  (core_y),
        .bit_i(core_bit),
        .sh_i (cnt_q[3:0]),
        .x_o  (core_x)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        wk_d    = wk_q;
        pacc_d  = pacc_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        res_d   = res_q;
        ext_d   = ext_q;
        flags_d = flags_q;
        load    = 1'b0;
        fin     = core_x;
        case (state_q)
            IDLE: if (is_multi(opsel)) begin
                op_d    = opsel;
                a_d     = a;
                b_d     = b;
                wk_d    = div_op ? {{W{1'b0}}, a} : '0;
                pacc_d  = (2*W)'(1);
                cnt_d   = '0;
                exp_d   = '0;
                load    = (div_op && b == '0) || (pow_op && b[4:0] == '0);
                fin     = div_op ? {a, {W{1'b1}}} : (2*W)'(1);
                state_d = load ? DONE : BUSY;
            end
            BUSY: begin
                // POW finishes one acc*a multiply every W steps, then restarts the partial product.
                wk_d    = last_it && pow_op ? '0 : core_x;
                pacc_d  = last_it && pow_op ? core_x : pacc_q;
                exp_d   = last_it && pow_op ? exp_q + 5'd1 : exp_q;
                cnt_d   = last_it ? '0 : cnt_q + 5'd1;
                load    = last_it && last_mul;
                state_d = load ? DONE : BUSY;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            res_d       = cur_op == ALU_MOD ? fin[2*W-1:W] : fin[W-1:0];
            ext_d       = cur_op == ALU_MOD ? fin[W-1:0] : fin[2*W-1:W];
            flags_d[ZF] = res_d == '0;
            flags_d[NF] = res_d[W-1];
            flags_d[CF] = div_op ? dz : ext_d != '0;
            flags_d[OF] = !div_op && ext_d != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wk_q    <= '0;
            pacc_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            ext_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wk_q    <= wk_d;
            pacc_q  <= pacc_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            ext_q   <= ext_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed MUL/DIV/MOD/POW against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opsel;
    logic [15:0] a, b, res, res_ext;
    logic        ready;
    logic [3:0]  flags;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .opsel  (opsel),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .res    (res),
        .res_ext(res_ext),
        .flags  (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [15:0] e, output logic [3:0] f,
                         output int lat);
        logic [31:0] p;
        logic        dv, z;
        dv  = op == ALU_DIV || op == ALU_MOD;
        z   = 1'b0;
        lat = 17;
        if (op == ALU_MUL) p = {16'h0, x} * {16'h0, y};
        else if (op == ALU_POW) begin
            p = 32'd1;
            for (int i = 0; i < int'(y[4:0]); i++) p = p * {16'h0, x};
            lat = 16 * int'(y[4:0]) + 1;
        end else if (y == 16'h0) begin
            z   = 1'b1;
            lat = 1;
            p   = {x, 16'hFFFF};
        end else p = {16'(x % y), 16'(x / y)};
        r = op == ALU_MOD ? p[31:16] : p[15:0];
        e = op == ALU_MOD ? p[15:0] : p[31:16];
        f = {r == 16'h0, r[15], dv ? z : e != 16'h0, !dv && e != 16'h0};
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 0; c < 700; c++) begin
            #1;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] er, ee;
        logic [3:0]  ef;
        int          el, lat;
        model(op, x, y, er, ee, ef, el);
        opsel = op;
        a     = x;
        b     = y;
        wait_done(lat);
        check($sformatf("op%0d %h,%h latency", op, x, y), lat, el);
        check($sformatf("op%0d %h,%h res", op, x, y), res, er);
        check($sformatf("op%0d %h,%h res_ext", op, x, y), res_ext, ee);
        check($sformatf("op%0d %h,%h flags", op, x, y), flags, ef);
        opsel = ALU_ADD;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat, hits, pos[2];
        logic [4:0]  op;
        logic [15:0] x, y;
        rst   = 1'b1;
        opsel = ALU_ADD;
        a     = '0;
        b     = '0;
        @(posedge clk);
        #1;
        check("ready in reset", ready, 0);
        @(posedge clk);
        #1;
        check("reset res", res, 0);
        check("reset res_ext", res_ext, 0);
        check("reset flags", flags, 0);
        rst = 1'b0;
        #1;
        check("idle add ready", ready, 1);

        run(ALU_MUL, 16'h1234, 16'h5678);
        run(ALU_DIV, 16'd1000, 16'd7);
        run(ALU_MOD, 16'd1000, 16'd7);
        run(ALU_DIV, 16'h00AB, 16'h0);
        run(ALU_MOD, 16'h00AB, 16'h0);
        run(ALU_POW, 16'd3, 16'd5);
        run(ALU_POW, 16'd2, 16'h0020);
        run(ALU_POW, 16'h0100, 16'd3);
        run(ALU_POW, 16'd3, 16'd31);
        run(ALU_DIV, 16'hFFFF, 16'h0001);
        run(ALU_MUL, 16'hFFFF, 16'hFFFF);

        opsel = ALU_ADD;
        a     = 16'd1;
        b     = 16'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("add ready stays", ready, 1);
            @(posedge clk);
            #1;
        end

        opsel  = ALU_MUL;
        a      = 16'h1234;
        b      = 16'h5678;
        hits   = 0;
        pos[0] = -1;
        pos[1] = -1;
        for (int c = 0; c < 36; c++) begin
            #1;
            if (ready) begin
                if (hits < 2) pos[hits] = c;
                hits++;
            end
            if (c == 35) opsel = ALU_ADD;
            @(posedge clk);
            #1;
        end
        check("b2b ready count", hits, 2);
        check("b2b first done", pos[0], 17);
        check("b2b second done", pos[1], 35);

        opsel = ALU_DIV;
        a     = 16'd50000;
        b     = 16'd3;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid reset ready", ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post reset res", res, 0);
        check("post reset res_ext", res_ext, 0);
        check("post reset flags", flags, 0);
        check("post reset ready", ready, 0);
        wait_done(lat);
        check("restart latency", lat, 17);
        check("restart quotient", res, 16'd16666);
        check("restart remainder", res_ext, 16'd2);
        opsel = ALU_ADD;
        @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: op = ALU_MUL;
                1: op = ALU_DIV;
                2: op = ALU_MOD;
                default: op = ALU_POW;
            endcase
            x = 16'($urandom);
            y = 16'($urandom);
            if (op == ALU_POW) y = {y[15:5], 5'($urandom_range(0, 5))};
            else if (op != ALU_MUL && $urandom_range(0, 7) == 0) y = 16'h0;
            run(op, x, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
